// File: rtl/nand_page_pack_if.sv
// Byte-stream in / buffer-write out bundle for nand_page_pack; PAGE_XSUM exists only with NAND_PACK_XSUM_EN.
// master = host/datapath side, slave = the packer.
interface nand_page_pack_if;
  logic        START;
  logic        ABORT;
  logic        BYTE_VLD;
  logic [7:0]  BYTE_DATA;
  logic        BYTE_RDY;
  logic [9:0]  WADDR;
  logic [31:0] WD;
  logic        WEN;
  logic        BUSY;
  logic        DONE;
  logic [10:0] WORD_CNT;
  logic        DROP_ERR;
`ifdef NAND_PACK_XSUM_EN
  logic [31:0] PAGE_XSUM;

  modport master (
    output START, ABORT, BYTE_VLD, BYTE_DATA,
    input  BYTE_RDY, WADDR, WD, WEN, BUSY, DONE, WORD_CNT, DROP_ERR, PAGE_XSUM
  );
  modport slave (
    input  START, ABORT, BYTE_VLD, BYTE_DATA,
    output BYTE_RDY, WADDR, WD, WEN, BUSY, DONE, WORD_CNT, DROP_ERR, PAGE_XSUM
  );
`else
  modport master (
    output START, ABORT, BYTE_VLD, BYTE_DATA,
    input  BYTE_RDY, WADDR, WD, WEN, BUSY, DONE, WORD_CNT, DROP_ERR
  );
  modport slave (
    input  START, ABORT, BYTE_VLD, BYTE_DATA,
    output BYTE_RDY, WADDR, WD, WEN, BUSY, DONE, WORD_CNT, DROP_ERR
  );
`endif
endinterface

// File: rtl/nand_page_pack.sv
// Packs the NAND byte stream into 32-bit little-endian page-buffer words; NAND_PACK_XSUM_EN adds PAGE_XSUM.
// Latency: WEN one cycle after the 4th (or final) byte is accepted; DONE one cycle after the final WEN.
// Backpressure: BYTE_RDY only in FILL, never stalls inside FILL; bytes offered elsewhere are dropped and flagged.
module nand_page_pack #(
  parameter int unsigned PAGE_BYTES = 2112,
  parameter int unsigned BASE_WORD  = 0,
  parameter logic [7:0]  PAD_BYTE   = 8'hFF
) (
  input logic             CLK,
  input logic             RESETN,
  nand_page_pack_if.slave bus
);

  localparam logic [12:0] LAST_CNT  = 13'(PAGE_BYTES - 1);
  localparam bit          FULL_LAST = ((PAGE_BYTES % 4) == 0);
  localparam logic [9:0]  BASE_ADDR = 10'(BASE_WORD % 1024);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH, S_DONE} state_t;

  state_t      state, state_d;
  logic [12:0] byte_cnt;
  logic [23:0] asm_q;
  logic [10:0] word_cnt;
  logic [9:0]  waddr_q;
  logic [31:0] wd_q;
  logic        wen_q;
  logic        done_q;
  logic        drop_q;

  logic [1:0]  lane;
  logic        accept;
  logic        last_byte;
  logic        emit;
  logic        start_acc;
  logic        final_wen;
  logic [31:0] word_d;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= S_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d   = state;
    lane      = byte_cnt[1:0];
    accept    = bus.BYTE_VLD && (state == S_FILL);
    last_byte = (byte_cnt == LAST_CNT);
    emit      = accept && !bus.ABORT && ((lane == 2'd3) || last_byte);
    start_acc = (state == S_IDLE) && bus.START && !bus.ABORT;
    // The last word is on the bus in DONE (full final word) or in FLUSH (padded word).
    final_wen = ((state == S_DONE) && wen_q) || (state == S_FLUSH);

    word_d[7:0]   = (lane == 2'd0) ? bus.BYTE_DATA : asm_q[7:0];
    word_d[15:8]  = (lane == 2'd1) ? bus.BYTE_DATA :
                    (lane >  2'd1) ? asm_q[15:8]   : PAD_BYTE;
    word_d[23:16] = (lane == 2'd2) ? bus.BYTE_DATA :
                    (lane == 2'd3) ? asm_q[23:16]  : PAD_BYTE;
    word_d[31:24] = (lane == 2'd3) ? bus.BYTE_DATA : PAD_BYTE;

    case (state)
      S_IDLE:  if (start_acc) state_d = S_FILL;
      S_FILL: begin
        if (bus.ABORT)                state_d = S_IDLE;
        else if (accept && last_byte) state_d = FULL_LAST ? S_DONE : S_FLUSH;
      end
      S_FLUSH: state_d = bus.ABORT ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      byte_cnt <= '0;
      asm_q    <= '0;
      word_cnt <= '0;
      waddr_q  <= '0;
      wd_q     <= '0;
      wen_q    <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      wen_q  <= emit;
      done_q <= final_wen && !bus.ABORT;

      // A byte dropped in the same cycle as START still counts against the new page.
      if (bus.BYTE_VLD && (state != S_FILL)) drop_q <= 1'b1;
      else if (start_acc)                    drop_q <= 1'b0;

      if (start_acc) begin
        byte_cnt <= '0;
        word_cnt <= '0;
      end else if (accept && !bus.ABORT) begin
        byte_cnt <= byte_cnt + 13'd1;
        case (lane)
          2'd0:    asm_q[7:0]   <= bus.BYTE_DATA;
          2'd1:    asm_q[15:8]  <= bus.BYTE_DATA;
          2'd2:    asm_q[23:16] <= bus.BYTE_DATA;
          default: ;
        endcase
        if (emit) begin
          wd_q     <= word_d;
          waddr_q  <= BASE_ADDR + word_cnt[9:0];
          word_cnt <= word_cnt + 11'd1;
        end
      end
    end
  end

`ifdef NAND_PACK_XSUM_EN
  logic [31:0] xsum_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)        xsum_q <= '0;
    else if (start_acc) xsum_q <= '0;
    else if (emit)      xsum_q <= xsum_q ^ word_d;
  end

  assign bus.PAGE_XSUM = xsum_q;
`endif

  assign bus.BYTE_RDY = (state == S_FILL);
  assign bus.BUSY     = (state == S_FILL) || (state == S_FLUSH);
  assign bus.WADDR    = waddr_q;
  assign bus.WD       = wd_q;
  assign bus.WEN      = wen_q;
  assign bus.DONE     = done_q;
  assign bus.WORD_CNT = word_cnt;
  assign bus.DROP_ERR = drop_q;

endmodule
